// File: rtl/sym_delay_search.sv
// Symbol delay estimator: sweeps candidate delays, counts symbol mismatches
// per window and publishes the lowest-error delay plus aligned ref data.
module sym_delay_search #(
    parameter int MAX_DELAY     = 64,
    parameter int DELAY_W       = 8,
    parameter int WINDOW        = 1000,
    parameter int CNT_W         = 11,
    parameter int LOCK_THRESH   = 0,
    parameter int DEFAULT_DELAY = 38
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               sym_clk_en,
    input  logic               start,
    input  logic [1:0]         ref_data,
    input  logic [1:0]         rx_data,
    output logic [1:0]         data_delay,
    output logic [DELAY_W-1:0] delay_est,
    output logic [CNT_W-1:0]   err_min,
    output logic               locked,
    output logic               busy,
    output logic               done
);

    localparam int SC_W = (CNT_W > DELAY_W + 1) ? CNT_W : DELAY_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_MEASURE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_line [MAX_DELAY-1];
    logic [DELAY_W-1:0] r_cand;
    logic [DELAY_W-1:0] r_best_c;
    logic [CNT_W-1:0]   r_err;
    logic [CNT_W-1:0]   r_best_err;
    logic [SC_W-1:0]    r_sym_cnt;

    logic [1:0]         w_taps [MAX_DELAY];
    logic [1:0]         w_tap_est;
    logic [1:0]         w_tap_cand;
    logic               w_mis;
    logic               w_take;
    logic [CNT_W-1:0]   w_best_err;
    logic [DELAY_W-1:0] w_best_c;

    // Tap 0 is the live input; tap d is the entry written d strobes ago.
    always_comb begin
        w_taps[0] = ref_data;
        for (int i = 1; i < MAX_DELAY; i++) begin
            w_taps[i] = r_line[i-1];
        end
    end

    always_comb begin
        w_tap_est  = 2'b00;
        w_tap_cand = 2'b00;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (delay_est == DELAY_W'(i)) w_tap_est = w_taps[i];
            if (r_cand == DELAY_W'(i)) w_tap_cand = w_taps[i];
        end
    end

    assign w_mis      = (rx_data != w_tap_cand);
    assign w_take     = (r_cand == '0) || (r_err < r_best_err);
    assign w_best_err = w_take ? r_err : r_best_err;
    assign w_best_c   = w_take ? r_cand : r_best_c;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_DELAY - 1; i++) begin
                r_line[i] <= 2'b00;
            end
            data_delay <= 2'b00;
        end else if (sym_clk_en) begin
            r_line[0] <= ref_data;
            for (int i = 1; i < MAX_DELAY - 1; i++) begin
                r_line[i] <= r_line[i-1];
            end
            data_delay <= w_tap_est;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cand     <= '0;
            r_best_c   <= '0;
            r_err      <= '0;
            r_best_err <= '0;
            r_sym_cnt  <= '0;
            delay_est  <= DELAY_W'(DEFAULT_DELAY);
            err_min    <= '0;
            locked     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        r_sym_cnt <= '0;
                        r_state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (sym_clk_en) begin
                        if (r_sym_cnt == SC_W'(MAX_DELAY - 1)) begin
                            r_sym_cnt <= '0;
                            r_cand    <= '0;
                            r_err     <= '0;
                            r_state   <= S_MEASURE;
                        end else begin
                            r_sym_cnt <= r_sym_cnt + 1'b1;
                        end
                    end
                end
                S_MEASURE: begin
                    if (sym_clk_en) begin
                        r_err <= r_err + CNT_W'(w_mis);
                        if (r_sym_cnt == SC_W'(WINDOW - 1)) begin
                            r_state <= S_EVAL;
                        end else begin
                            r_sym_cnt <= r_sym_cnt + 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    r_best_err <= w_best_err;
                    r_best_c   <= w_best_c;
                    // Publish on entry to DONE so results align with the pulse.
                    if (r_cand == DELAY_W'(MAX_DELAY - 1)) begin
                        err_min <= w_best_err;
                        locked  <= (w_best_err <= CNT_W'(LOCK_THRESH));
                        if (w_best_err <= CNT_W'(LOCK_THRESH)) begin
                            delay_est <= w_best_c;
                        end
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cand    <= r_cand + 1'b1;
                        r_err     <= '0;
                        r_sym_cnt <= '0;
                        r_state   <= S_MEASURE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sym_delay_search.sv
// Directed bench for sym_delay_search: scoreboarded search results and
// data_delay stream, boundary delays, tie-break, unlock, restart and reset abort.
module tb_sym_delay_search;

    localparam int MD  = 8;
    localparam int DW  = 3;
    localparam int WIN = 16;
    localparam int CW  = 5;
    localparam int DEF = 3;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b0;
    logic          sym_clk_en = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    ref_data = 2'b00;
    logic [1:0]    rx_data = 2'b00;
    logic [1:0]    data_delay;
    logic [DW-1:0] delay_est;
    logic [CW-1:0] err_min;
    logic          locked;
    logic          busy;
    logic          done;

    sym_delay_search #(
        .MAX_DELAY(MD), .DELAY_W(DW), .WINDOW(WIN), .CNT_W(CW),
        .LOCK_THRESH(0), .DEFAULT_DELAY(DEF)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .sym_clk_en(sym_clk_en),
        .start(start), .ref_data(ref_data), .rx_data(rx_data),
        .data_delay(data_delay), .delay_est(delay_est), .err_min(err_min),
        .locked(locked), .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [DW-1:0] est;
        logic          lck;
        bit            zero_err;
    } exp_t;

    exp_t          q_res[$];
    logic [1:0]    q_dd[$];
    logic [1:0]    hist[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc_n = 0;
    int            done_n = 0;
    int            strobes_busy = 0;
    int            mode = 0;
    int            tdel = 0;
    int            pat = 0;
    logic [DW-1:0] exp_est = DW'(DEF);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] hist_at(input int d);
        if (hist.size() > d) return hist[hist.size()-1-d];
        return 2'b00;
    endfunction

    task automatic cyc(input bit st);
        logic [1:0] e;
        exp_t       x;
        bit         en;
        @(negedge sys_clk);
        if (q_dd.size() > 0) begin
            e = q_dd.pop_front();
            chk("data_delay", data_delay, e);
        end
        if (done) begin
            done_n++;
            if (q_res.size() > 0) begin
                x = q_res.pop_front();
                chk("delay_est", delay_est, x.est);
                chk("locked", locked, x.lck);
                if (x.zero_err) chk("err_min", err_min, 0);
                else chk("err_min_nonzero", err_min != 0, 1);
                exp_est = x.est;
            end else begin
                chk("done_unexpected", 1, 0);
            end
        end
        en = (cyc_n % 4 == 0);
        if (en && busy) strobes_busy++;
        start      = st;
        sym_clk_en = en;
        if (en) begin
            if (mode == 1) begin
                ref_data = 2'(pat % 4);
                pat++;
            end else begin
                ref_data = 2'($urandom_range(0, 3));
            end
            hist.push_back(ref_data);
            if (hist.size() > 16) void'(hist.pop_front());
            if (mode == 2) rx_data = 2'($urandom_range(0, 3));
            else rx_data = hist_at(tdel);
            q_dd.push_back(hist_at(int'(exp_est)));
        end
        cyc_n++;
    endtask

    task automatic search(input int m, input int d, input logic [DW-1:0] e,
                          input logic l, input bit z, input bit extra);
        int d0;
        int n;
        mode = m;
        tdel = d;
        q_res.push_back('{e, l, z});
        d0 = done_n;
        strobes_busy = 0;
        cyc(1'b1);
        cyc(1'b0);
        chk("busy_after_start", busy, 1);
        n = 0;
        while (done_n == d0 && n < 3000) begin
            cyc(extra && n == 200);
            n++;
        end
        repeat (6) cyc(1'b0);
        chk("one_done_pulse", done_n - d0, 1);
        chk("busy_after_done", busy, 0);
        chk("search_strobes", strobes_busy, MD + MD * WIN);
    endtask

    initial begin
        int d0;
        int n;
        repeat (3) @(negedge sys_clk);
        #1;
        chk("rst_data_delay", data_delay, 0);
        chk("rst_delay_est", delay_est, DEF);
        chk("rst_err_min", err_min, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        repeat (4) cyc(1'b0);

        search(2, 0, DW'(DEF), 1'b0, 1'b0, 1'b0);
        search(0, 5, 3'd5, 1'b1, 1'b1, 1'b0);
        repeat (40) cyc(1'b0);
        search(0, 0, 3'd0, 1'b1, 1'b1, 1'b0);
        search(0, 7, 3'd7, 1'b1, 1'b1, 1'b0);
        search(1, 6, 3'd2, 1'b1, 1'b1, 1'b0);
        search(0, 5, 3'd5, 1'b1, 1'b1, 1'b1);

        // Abort partway through candidate 4's window.
        mode = 0;
        tdel = 2;
        d0 = done_n;
        strobes_busy = 0;
        cyc(1'b1);
        n = 0;
        while (strobes_busy < MD + 4 * WIN + 8 && n < 3000) begin
            cyc(1'b0);
            n++;
        end
        chk("abort_reached", strobes_busy, MD + 4 * WIN + 8);
        @(posedge sys_clk);
        #2;
        reset      = 1'b0;
        sym_clk_en = 1'b0;
        start      = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_delay_est", delay_est, DEF);
        chk("abort_locked", locked, 0);
        chk("abort_err_min", err_min, 0);
        chk("abort_data_delay", data_delay, 0);
        chk("abort_no_done", done_n - d0, 0);
        q_dd.delete();
        hist.delete();
        exp_est = DW'(DEF);
        repeat (3) @(negedge sys_clk);
        reset = 1'b1;
        repeat (4) cyc(1'b0);
        search(0, 4, 3'd4, 1'b1, 1'b1, 1'b0);
        repeat (20) cyc(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sym_delay_search.md
Name: sym_delay_search

Overview:
- Automatic estimator for the symbol delay between transmitted reference data and received symbol decisions.
- Sweeps every candidate delay, counts symbol mismatches over a fixed window at each candidate, and selects the delay with the fewest errors.
- Sits beside the BER/MER measurement path. It produces the delay value that the gold-standard alignment otherwise hard-codes (38), plus the aligned reference data stream.

Parameters:
- MAX_DELAY, 64: number of candidate delays, 0..MAX_DELAY-1.
- DELAY_W, 8: width of the delay estimate; 2^DELAY_W >= MAX_DELAY.
- WINDOW, 1000: counted symbols per candidate.
- CNT_W, 11: error counter width; 2^CNT_W-1 >= WINDOW, so the counter never overflows.
- LOCK_THRESH, 0: maximum best-case error count that still declares lock.
- DEFAULT_DELAY, 38: delay_est value out of reset.

Ports:
- sys_clk  in  1  system clock; the single clock domain.
- reset  in  1  asynchronous, active-low reset.
- sym_clk_en  in  1  one-sys_clk-wide symbol strobe.
- start  in  1  single-cycle request to begin a search.
- ref_data  in  2  transmitted symbol data; sampled on sym_clk_en.
- rx_data  in  2  received symbol decisions; sampled on sym_clk_en.
- data_delay  out  2  ref_data delayed by delay_est symbols.
- delay_est  out  DELAY_W  current delay estimate.
- err_min  out  CNT_W  error count of the best candidate from the last search.
- locked  out  1  last search met LOCK_THRESH.
- busy  out  1  search in progress.
- done  out  1  one-cycle pulse when a search completes.

Behaviour:
- Reset values (reset low, asynchronous):
  - Delay line and data_delay = 0.
  - delay_est = DEFAULT_DELAY.
  - err_min = 0; locked = 0; busy = 0; done = 0.
  - FSM in IDLE; all counters 0.
- Delay line:
  - Shift register of MAX_DELAY-1 two-bit entries, advanced only on sym_clk_en.
  - tap(d) = ref_data when d = 0, else the entry written d strobes ago.
  - Each counted strobe compares rx_data against tap(c) for the current candidate c.
  - A mismatch is any bit difference and counts as one symbol error.
- data_delay: registered on sym_clk_en from tap(delay_est); one sys_clk latency after the strobe. It always uses the held delay_est, including during a search.
- FSM states:
  - IDLE: busy = 0. A start pulse moves to FILL and sets busy = 1. start is ignored in every other state.
  - FILL: waits MAX_DELAY sym_clk_en strobes so every tap holds valid data. Then c = 0, err count = 0, go to MEASURE.
  - MEASURE: on each strobe, increment the symbol counter and add the mismatch. After the WINDOW-th strobe, go to EVAL.
  - EVAL: exactly one sys_clk cycle.
    - If c = 0 or err < best_err: best_err = err, best_c = c. Strictly-less comparison means ties keep the lowest delay.
    - If c = MAX_DELAY-1, go to DONE; otherwise c++, clear err and the symbol counter, go to MEASURE.
    - A strobe landing in EVAL is neither counted nor attributed to any candidate; the delay line still shifts.
  - DONE: one cycle, then IDLE.
    - err_min = best_err; locked = (best_err <= LOCK_THRESH).
    - delay_est = best_c only if locked; otherwise delay_est is unchanged.
    - done = 1 for this cycle; busy returns to 0 on the next cycle.
- Outputs during a search: delay_est, err_min and locked hold their previous values until DONE.
- Reset mid-search: aborts immediately to the reset values. No partial result is ever published.
- Duration: (MAX_DELAY + MAX_DELAY*WINDOW) strobes plus MAX_DELAY+1 non-strobe cycles. This assumes no strobe lands in EVAL, which holds when strobes are at least 2 sys_clk cycles apart.

Test Plan (bench overrides MAX_DELAY=8, DELAY_W=3, WINDOW=16, CNT_W=5, DEFAULT_DELAY=3; sym_clk_en every 4th cycle):
- Random ref_data, rx_data = ref_data delayed 5 strobes; pulse start -> busy for 136 strobes, done pulse, delay_est=5, err_min=0, locked=1; data_delay then equals rx_data on every strobe.
- Boundary delays: true delay 0, then 7 -> delay_est=0 and delay_est=7 respectively, locked=1.
- ref_data repeating 0,1,2,3 with true delay 6 -> candidates 2 and 6 both score 0 errors; tie resolves to delay_est=2.
- rx_data independent random -> locked=0, delay_est stays 3, err_min>0.
- start pulsed again while busy -> ignored; exactly one done pulse and duration unchanged.
- reset asserted during MEASURE of candidate 4 -> busy=0, delay_est=3, locked=0 immediately; a subsequent start completes a normal search.
